apb_slave_regs: RTL and testbench
=================================

Name: apb_slave_regs

Overview:
- APB3 completer that sits directly downstream of the team's APB master and terminates its transfers.
- Holds a bank of NUM_REGS word-wide read/write registers with a programmable number of wait states.
- Flags illegal accesses with pslverr and keeps a free-running count of completed transfers for debug and coverage.

Parameters:
- ADDR_WIDTH, 32, width of paddr.
- DATA_WIDTH, 32, width of pwdata/prdata and of each register.
- NUM_REGS, 8, number of registers; power of two, at least 2.
- WAIT_STATES, 1, ACCESS cycles with pready=0 before completion; 0 to 15.

Ports:
- clk  in  1  system clock; all logic is rising-edge triggered.
- rst  in  1  synchronous, active-high reset.
- paddr  in  ADDR_WIDTH  byte address from the master.
- pwdata  in  DATA_WIDTH  write data.
- pwrite  in  1  1 = write, 0 = read.
- psel  in  1  slave select.
- penable  in  1  access phase indicator.
- pready  out  1  transfer completes in this cycle.
- prdata  out  DATA_WIDTH  read data; valid only while pready=1 on a read.
- pslverr  out  1  error response; valid only while pready=1.
- reg0_q  out  DATA_WIDTH  live value of register 0, exported to the fabric.
- xfer_count  out  16  number of completed transfers, including errored ones.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM goes to IDLE.
  - All registers, xfer_count and the wait counter clear to 0.
  - pready, pslverr and prdata are 0 in the following cycle.
  - Reset during an open transfer aborts it; no write commits.
- FSM states: IDLE, SETUP, ACCESS. The state is registered.
- IDLE:
  - psel=1 and penable=0 -> SETUP.
  - psel=1 and penable=1 without a setup cycle is a protocol violation; it is ignored and the FSM stays in IDLE.
- SETUP:
  - Load the wait counter with WAIT_STATES.
  - Go to ACCESS unconditionally.
  - Latch paddr and pwrite for the error decode.
- ACCESS:
  - If psel=0: abort to IDLE, no write, no count.
  - Else if wait counter != 0: decrement it, pready=0.
  - Else: pready=1 and the transfer completes at this edge.
  - After completion, go to SETUP if psel=1 and penable=0 at that edge; otherwise go to IDLE.
- pready is combinational: pready = (state==ACCESS) & psel & penable & (cnt==0).
- Completion latency from the SETUP cycle is 1+WAIT_STATES cycles; pready is high in ACCESS cycle number WAIT_STATES+1.
- Address decode:
  - idx = paddr[2 +: log2(NUM_REGS)].
  - An error is raised when paddr[1:0] != 0 or paddr >= NUM_REGS*4.
- Error transfer: pslverr=1 with pready; no register changes; prdata=0.
- Write: at the completing edge with no error, regs[idx] <= pwdata.
- Read: while pready=1, pwrite=0 and no error, prdata = regs[idx]; otherwise prdata = 0.
- prdata is driven combinationally.
- Read-after-write in back-to-back transfers returns the new value, because the write commits before the next SETUP.
- xfer_count increments by 1 at each completing edge and wraps from 0xFFFF to 0x0000.
- Mid-access changes: paddr, pwrite and pwdata changing during ACCESS is a master violation. The slave uses the live pwdata and the address latched in SETUP.
- No byte strobes; every write is full word.

Decomposition:
- Shared package apb_pkg holds:
  - the apb_state_t enum (APB_IDLE, APB_SETUP, APB_ACCESS);
  - the APB_ADDR_W and APB_DATA_W defaults;
  - the helper constant for the word-offset shift (2).
- One natural sub-module: apb_regbank, a NUM_REGS x DATA_WIDTH array with write enable, index and read mux, exposing reg0_q.
- The FSM, wait counter, decode and xfer_count stay in the top level.

Test Plan:
- Write 0x12345678 to addr 0x0, WAIT_STATES=1 -> pready high in the 2nd ACCESS cycle, pslverr=0, reg0_q=0x12345678, xfer_count=1.
- Read addr 0x0 immediately after that write -> prdata=0x12345678 in the pready cycle, xfer_count=2.
- Write 0xDEADBEEF to 0x1C, then to 0x20 (NUM_REGS=8) -> first completes cleanly; second gives pslverr=1 with prdata=0 and leaves all registers unchanged.
- Write to misaligned addr 0x6 -> pslverr=1, no register change, xfer_count still increments.
- WAIT_STATES=0 and WAIT_STATES=3 builds -> pready in ACCESS cycle 1 and 4 respectively; drop psel in ACCESS cycle 2 of the 3-wait build -> return to IDLE, no write, count unchanged.
- Assert rst mid-ACCESS of a write of 0xA5A5A5A5 to 0x4 -> reg1=0, pready=0, xfer_count=0; a later read of 0x4 returns 0x00000000.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, default bus widths and word-offset shift.
package apb_pkg;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_state_t;

    localparam int unsigned APB_ADDR_W     = 32;
    localparam int unsigned APB_DATA_W     = 32;
    localparam int unsigned APB_WORD_SHIFT = 2;

endpackage

// File: rtl/apb_slave_regs_if.sv
// APB3 bus bundle between a requester (master) and a completer (slave).
interface apb_slave_regs_if
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = APB_ADDR_W,
    parameter int unsigned DATA_WIDTH = APB_DATA_W
) ();

    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pwrite;
    logic                  psel;
    logic                  penable;
    logic                  pready;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pslverr;

    modport master (
        output paddr, pwdata, pwrite, psel, penable,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  paddr, pwdata, pwrite, psel, penable,
        output pready, prdata, pslverr
    );

endinterface

// File: rtl/apb_regbank.sv
// NUM_REGS x DATA_WIDTH register array with one write port and one read mux.
module apb_regbank #(
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [$clog2(NUM_REGS)-1:0] idx,
    input  logic [DATA_WIDTH-1:0]       wdata,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic [DATA_WIDTH-1:0]       reg0_q
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else if (we) begin
            regs_q[idx] <= wdata;
        end
    end

    assign rdata  = regs_q[idx];
    assign reg0_q = regs_q[0];

endmodule

// File: rtl/apb_slave_regs.sv
// APB3 completer: register bank behind an IDLE/SETUP/ACCESS FSM with programmable wait
// states, address-error response and a free-running completed-transfer counter.
module apb_slave_regs
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = APB_ADDR_W,
    parameter int unsigned DATA_WIDTH  = APB_DATA_W,
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    apb_slave_regs_if.slave       apb,
    output logic [DATA_WIDTH-1:0] reg0_q,
    output logic [15:0]           xfer_count
);

    localparam int unsigned IDX_W  = $clog2(NUM_REGS);
    localparam int unsigned HI_LSB = APB_WORD_SHIFT + IDX_W;

    apb_state_t state_q, state_d;

    logic [3:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [15:0]           count_q;

    logic                  done;
    logic                  addr_err;
    logic                  wr_en;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] rdata;

    // Decode works on the address captured in SETUP, not the live bus.
    assign idx      = addr_q[APB_WORD_SHIFT +: IDX_W];
    assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[ADDR_WIDTH-1:HI_LSB] != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= APB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            APB_IDLE: begin
                if (apb.psel && !apb.penable) begin
                    state_d = APB_SETUP;
                end
            end
            APB_SETUP: state_d = APB_ACCESS;
            APB_ACCESS: begin
                if (!apb.psel) begin
                    state_d = APB_IDLE;
                end else if (done) begin
                    state_d = (apb.psel && !apb.penable) ? APB_SETUP : APB_IDLE;
                end
            end
            default: state_d = APB_IDLE;
        endcase
    end

    always_comb begin
        done        = (state_q == APB_ACCESS) && apb.psel && apb.penable && (cnt_q == 4'd0);
        wr_en       = done && write_q && !addr_err;
        apb.pready  = done;
        apb.pslverr = done && addr_err;
        apb.prdata  = (done && !write_q && !addr_err) ? rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            count_q <= 16'd0;
        end else begin
            if (state_q == APB_SETUP) begin
                cnt_q   <= 4'(WAIT_STATES);
                addr_q  <= apb.paddr;
                write_q <= apb.pwrite;
            end else if ((state_q == APB_ACCESS) && apb.psel && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (done) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign xfer_count = count_q;

    apb_regbank #(
        .NUM_REGS   (NUM_REGS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_regbank (
        .clk    (clk),
        .rst    (rst),
        .we     (wr_en),
        .idx    (idx),
        .wdata  (apb.pwdata),
        .rdata  (rdata),
        .reg0_q (reg0_q)
    );

endmodule

// File: tb/tb_apb_slave_regs.sv
// Directed bench for apb_slave_regs: three builds (0/1/3 wait states) share one stimulus bus.
module tb_apb_slave_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic        psel;
    logic        penable;
    int          ws_sel;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    apb_slave_regs_if bus0 ();
    apb_slave_regs_if bus1 ();
    apb_slave_regs_if bus3 ();

    // Only the selected build sees psel; the others sit in IDLE.
    assign bus0.paddr = paddr;  assign bus0.pwdata = pwdata;  assign bus0.pwrite = pwrite;
    assign bus1.paddr = paddr;  assign bus1.pwdata = pwdata;  assign bus1.pwrite = pwrite;
    assign bus3.paddr = paddr;  assign bus3.pwdata = pwdata;  assign bus3.pwrite = pwrite;
    assign bus0.penable = penable;  assign bus0.psel = psel && (ws_sel == 0);
    assign bus1.penable = penable;  assign bus1.psel = psel && (ws_sel == 1);
    assign bus3.penable = penable;  assign bus3.psel = psel && (ws_sel == 3);

    logic [31:0] reg0_0, reg0_1, reg0_3;
    logic [15:0] cnt_0, cnt_1, cnt_3;

    apb_slave_regs #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .apb(bus0), .reg0_q(reg0_0), .xfer_count(cnt_0)
    );
    apb_slave_regs #(.WAIT_STATES(1)) dut1 (
        .clk(clk), .rst(rst), .apb(bus1), .reg0_q(reg0_1), .xfer_count(cnt_1)
    );
    apb_slave_regs #(.WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst), .apb(bus3), .reg0_q(reg0_3), .xfer_count(cnt_3)
    );

    logic        o_pready;
    logic        o_pslverr;
    logic [31:0] o_prdata;
    logic [31:0] o_reg0;
    logic [15:0] o_cnt;

    always_comb begin
        o_pready  = bus1.pready;
        o_pslverr = bus1.pslverr;
        o_prdata  = bus1.prdata;
        o_reg0    = reg0_1;
        o_cnt     = cnt_1;
        if (ws_sel == 0) begin
            o_pready = bus0.pready;  o_pslverr = bus0.pslverr;  o_prdata = bus0.prdata;
            o_reg0   = reg0_0;       o_cnt     = cnt_0;
        end else if (ws_sel == 3) begin
            o_pready = bus3.pready;  o_pslverr = bus3.pslverr;  o_prdata = bus3.prdata;
            o_reg0   = reg0_3;       o_cnt     = cnt_3;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Full transfer on the selected build; expectations are queued before driving.
    task automatic xfer(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic w, input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        int   n;
        bit   got;
        e.rd  = exp_rd;
        e.err = exp_err;
        e.cyc = ws_sel + 1;
        sb.push_back(e);
        @(posedge clk); #1;
        psel = 1'b1;  penable = 1'b0;  paddr = a;  pwrite = w;  pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            got = o_pready;
        end
        e = sb.pop_front();
        check({tag, " ready"}, 32'(got), 32'd1);
        check({tag, " access cycle"}, 32'(n), 32'(e.cyc));
        check({tag, " prdata"}, o_prdata, e.rd);
        check({tag, " pslverr"}, 32'(o_pslverr), 32'(e.err));
        @(posedge clk); #1;
        psel = 1'b0;  penable = 1'b0;
    endtask

    initial begin
        rst = 1'b1;  psel = 1'b0;  penable = 1'b0;  pwrite = 1'b0;
        paddr = '0;  pwdata = '0;  ws_sel = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset pready", 32'(o_pready), 32'd0);
        check("reset pslverr", 32'(o_pslverr), 32'd0);
        check("reset prdata", o_prdata, 32'd0);
        check("reset reg0", o_reg0, 32'd0);
        check("reset count", 32'(o_cnt), 32'd0);

        xfer("wr0", 32'h0, 32'h12345678, 1'b1, 32'h0, 1'b0);
        check("wr0 reg0", o_reg0, 32'h12345678);
        check("wr0 count", 32'(o_cnt), 32'd1);
        xfer("rd0", 32'h0, 32'h0, 1'b0, 32'h12345678, 1'b0);
        check("rd0 count", 32'(o_cnt), 32'd2);
        xfer("wr1c", 32'h1C, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
        xfer("wr20", 32'h20, 32'hDEADBEEF, 1'b1, 32'h0, 1'b1);
        check("wr20 count", 32'(o_cnt), 32'd4);
        check("wr20 reg0", o_reg0, 32'h12345678);
        xfer("rd1c", 32'h1C, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0);
        xfer("rd20", 32'h20, 32'h0, 1'b0, 32'h0, 1'b1);
        xfer("wr6", 32'h6, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b1);
        check("wr6 count", 32'(o_cnt), 32'd7);
        xfer("rd4", 32'h4, 32'h0, 1'b0, 32'h0, 1'b0);

        // Enable without a setup cycle must be ignored.
        @(posedge clk); #1;
        psel = 1'b1;  penable = 1'b1;  paddr = 32'h0;  pwrite = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("no-setup pready", 32'(o_pready), 32'd0);
        end
        @(posedge clk); #1;
        psel = 1'b0;  penable = 1'b0;
        check("no-setup count", 32'(o_cnt), 32'd8);

        // Reset lands in the wait cycle of a write; bus stays asserted across it.
        @(posedge clk); #1;
        psel = 1'b1;  penable = 1'b0;  paddr = 32'h4;  pwrite = 1'b1;  pwdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;  psel = 1'b0;  penable = 1'b0;
        @(negedge clk);
        check("rst-mid pready", 32'(o_pready), 32'd0);
        check("rst-mid count", 32'(o_cnt), 32'd0);
        check("rst-mid reg0", o_reg0, 32'd0);
        xfer("rst-mid rd4", 32'h4, 32'h0, 1'b0, 32'h0, 1'b0);
        check("rst-mid rd count", 32'(o_cnt), 32'd1);

        ws_sel = 0;
        xfer("ws0 wr0", 32'h0, 32'h11111111, 1'b1, 32'h0, 1'b0);
        check("ws0 reg0", o_reg0, 32'h11111111);
        xfer("ws0 rd0", 32'h0, 32'h0, 1'b0, 32'h11111111, 1'b0);
        check("ws0 count", 32'(o_cnt), 32'd2);

        ws_sel = 3;
        xfer("ws3 wr8", 32'h8, 32'h33333333, 1'b1, 32'h0, 1'b0);
        check("ws3 count", 32'(o_cnt), 32'd1);
        @(posedge clk); #1;
        psel = 1'b1;  penable = 1'b0;  paddr = 32'h0;  pwrite = 1'b1;  pwdata = 32'h55555555;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("abort pready", 32'(o_pready), 32'd0);
        psel = 1'b0;  penable = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("abort reg0", o_reg0, 32'd0);
        check("abort count", 32'(o_cnt), 32'd1);
        xfer("ws3 rd8", 32'h8, 32'h0, 1'b0, 32'h33333333, 1'b0);
        xfer("ws3 rd0", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("ws3 final count", 32'(o_cnt), 32'd3);
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
